// File: rtl/mem_if_pkg.sv
// Shared types and limits for the processor-to-cache handshake controller.
package mem_if_pkg;

    localparam int MAX_DCH = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } dch_state_t;

    typedef enum logic [1:0] {
        I_IDLE,
        I_REQ,
        I_REL
    } ich_state_t;

endpackage

// File: rtl/mem_ch_fsm.sv
// One data-channel request/ready/release handshake FSM. With MEMIF_TIMEOUT_EN
// defined, a REQ that sees no data_ready for TIMEOUT_CYC cycles is aborted.
module mem_ch_fsm
    import mem_if_pkg::*;
#(
    parameter int RELEASE_CYC = 1,
`ifdef MEMIF_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 64,
`endif
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic memop,
    input  logic memwr,
    input  logic data_ready,
    output logic data_read,
    output logic data_write,
    output logic data_done,
    output logic data_err,
    output logic freeze
);

    localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYC);

    dch_state_t       state_q, state_d;
    logic             wr_q, wr_d;
    logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;

`ifdef MEMIF_TIMEOUT_EN
    // The counter holds the REQ cycles already completed, so the abort lands
    // in the TIMEOUT_CYC-th cycle of REQ.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through this block can leave a signal unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        rel_cnt_d  = rel_cnt_q;
        data_read  = 1'b0;
        data_write = 1'b0;
        data_done  = 1'b0;
        data_err   = 1'b0;
        freeze     = 1'b0;
`ifdef MEMIF_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                data_read  = memop & ~memwr;
                data_write = memop & memwr;
                freeze     = memop;
                if (memop) begin
                    state_d  = REQ;
                    wr_d     = memwr;
`ifdef MEMIF_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            REQ: begin
                data_read  = ~wr_q;
                data_write = wr_q;
                freeze     = ~data_ready;
                if (data_ready) begin
                    data_done = 1'b1;
                    state_d   = REL;
                    rel_cnt_d = REL_LOAD;
                end
`ifdef MEMIF_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    data_err  = 1'b1;
                    state_d   = REL;
                    rel_cnt_d = REL_LOAD;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
`endif
            end
            REL: begin
                rel_cnt_d = (rel_cnt_q != '0) ? rel_cnt_q - CNT_W'(1) : '0;
                if (rel_cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle abandons any access: nothing reaches the cache or pipeline.
        if (rst) begin
            data_read  = 1'b0;
            data_write = 1'b0;
            data_done  = 1'b0;
            data_err   = 1'b0;
            freeze     = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            rel_cnt_q <= '0;
`ifdef MEMIF_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rel_cnt_q <= rel_cnt_d;
`ifdef MEMIF_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Processor-to-cache handshake controller: one I-fetch channel and NUM_DCH data
// channels. Optional request timeout is enabled by defining MEMIF_TIMEOUT_EN.
module mem_handshake_ctrl
    import mem_if_pkg::*;
#(
    parameter int NUM_DCH     = 2,
    parameter int RELEASE_CYC = 1,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DCH-1:0] memop,
    input  logic [NUM_DCH-1:0] memwr,
    input  logic [NUM_DCH-1:0] data_ready,
    output logic [NUM_DCH-1:0] data_read,
    output logic [NUM_DCH-1:0] data_write,
    output logic [NUM_DCH-1:0] data_done,
    output logic [NUM_DCH-1:0] data_err,
    input  logic               inst_ready,
    output logic               inst_read,
    output logic               inst_done,
    output logic               stall
);

    if (NUM_DCH < 1 || NUM_DCH > MAX_DCH || RELEASE_CYC < 1 ||
        (1 << CNT_W) <= RELEASE_CYC || (1 << CNT_W) <= TIMEOUT_CYC) begin : g_param_check
        $error("mem_handshake_ctrl: parameter out of range");
    end

    logic [NUM_DCH-1:0] ch_freeze;
    logic               freeze;

    for (genvar g = 0; g < NUM_DCH; g++) begin : g_ch
        mem_ch_fsm #(
            .RELEASE_CYC (RELEASE_CYC),
`ifdef MEMIF_TIMEOUT_EN
            .TIMEOUT_CYC (TIMEOUT_CYC),
`endif
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .memop      (memop[g]),
            .memwr      (memwr[g]),
            .data_ready (data_ready[g]),
            .data_read  (data_read[g]),
            .data_write (data_write[g]),
            .data_done  (data_done[g]),
            .data_err   (data_err[g]),
            .freeze     (ch_freeze[g])
        );
    end

    // A data access that is starting or still waiting shuts down I-fetch.
    assign freeze = |ch_freeze;
    assign stall  = ~rst & (|(memop & ~data_done));

    ich_state_t i_state_q, i_state_d;

    always_comb begin
        i_state_d = i_state_q;
        inst_read = 1'b0;
        inst_done = 1'b0;
        case (i_state_q)
            I_IDLE: begin
                if (!freeze) begin
                    i_state_d = I_REQ;
                end
            end
            I_REQ: begin
                inst_read = 1'b1;
                if (inst_ready) begin
                    inst_done = 1'b1;
                    i_state_d = I_REL;
                end else if (freeze) begin
                    i_state_d = I_IDLE;
                end
            end
            I_REL:   i_state_d = I_IDLE;
            default: i_state_d = I_IDLE;
        endcase

        if (rst) begin
            inst_read = 1'b0;
            inst_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state_q <= I_IDLE;
        end else begin
            i_state_q <= i_state_d;
        end
    end

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Self-checking bench for mem_handshake_ctrl: directed protocol scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_mem_handshake_ctrl;

    localparam int NUM_DCH     = 2;
    localparam int RELEASE_CYC = 3;
    localparam int TIMEOUT_CYC = 8;
    localparam int CNT_W       = 8;
`ifdef MEMIF_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_DCH-1:0] memop, memwr, data_ready;
    logic [NUM_DCH-1:0] data_read, data_write, data_done, data_err;
    logic               inst_ready, inst_read, inst_done, stall;

    int n_cmp = 0;
    int n_bad = 0;

    // Model view of each channel: waiting for the cache, how many cycles it has
    // waited, which direction it latched, and how many quiet cycles remain.
    bit m_req [NUM_DCH];
    int m_age [NUM_DCH];
    bit m_wr  [NUM_DCH];
    int m_gap [NUM_DCH];
    bit m_fetch = 1'b0;
    bit m_cool  = 1'b0;
    logic [NUM_DCH-1:0] prev_fin = '0;

    mem_handshake_ctrl #(
        .NUM_DCH     (NUM_DCH),
        .RELEASE_CYC (RELEASE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memop      (memop),
        .memwr      (memwr),
        .data_ready (data_ready),
        .data_read  (data_read),
        .data_write (data_write),
        .data_done  (data_done),
        .data_err   (data_err),
        .inst_ready (inst_ready),
        .inst_read  (inst_read),
        .inst_done  (inst_done),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Per-cycle reference check, evaluated mid-cycle with inputs stable.
    initial begin : compare
        logic [NUM_DCH-1:0] e_rd, e_wr, e_dn, e_er;
        logic e_frz, e_ir, e_id, e_st;
        for (int i = 0; i < NUM_DCH; i++) begin
            m_req[i] = 1'b0; m_age[i] = 0; m_wr[i] = 1'b0; m_gap[i] = 0;
        end
        forever begin
            @(negedge clk);
            e_rd = '0; e_wr = '0; e_dn = '0; e_er = '0;
            e_frz = 1'b0; e_ir = 1'b0; e_id = 1'b0; e_st = 1'b0;
            if (rst) begin
                for (int i = 0; i < NUM_DCH; i++) begin
                    m_req[i] = 1'b0; m_age[i] = 0; m_wr[i] = 1'b0; m_gap[i] = 0;
                end
                m_fetch = 1'b0;
                m_cool  = 1'b0;
            end else begin
                for (int i = 0; i < NUM_DCH; i++) begin
                    if (m_gap[i] > 0) begin
                        m_gap[i] = m_gap[i] - 1;
                    end else if (m_req[i]) begin
                        e_rd[i] = !m_wr[i];
                        e_wr[i] = m_wr[i];
                        if (!data_ready[i]) e_frz = 1'b1;
                        if (data_ready[i]) begin
                            e_dn[i]  = 1'b1;
                            m_req[i] = 1'b0;
                            m_gap[i] = RELEASE_CYC;
                        end else if (TO_EN && (m_age[i] + 1 == TIMEOUT_CYC)) begin
                            e_er[i]  = 1'b1;
                            m_req[i] = 1'b0;
                            m_gap[i] = RELEASE_CYC;
                        end else begin
                            m_age[i] = m_age[i] + 1;
                        end
                    end else if (memop[i]) begin
                        e_rd[i]  = !memwr[i];
                        e_wr[i]  = memwr[i];
                        e_frz    = 1'b1;
                        m_req[i] = 1'b1;
                        m_wr[i]  = memwr[i];
                        m_age[i] = 0;
                    end
                end
                if (m_cool) begin
                    m_cool = 1'b0;
                end else if (m_fetch) begin
                    e_ir = 1'b1;
                    if (inst_ready) begin
                        e_id    = 1'b1;
                        m_fetch = 1'b0;
                        m_cool  = 1'b1;
                    end else if (e_frz) begin
                        m_fetch = 1'b0;
                    end
                end else if (!e_frz) begin
                    m_fetch = 1'b1;
                end
                e_st = |(memop & ~e_dn);
            end
            check("model data_read",  32'(data_read),  32'(e_rd));
            check("model data_write", 32'(data_write), 32'(e_wr));
            check("model data_done",  32'(data_done),  32'(e_dn));
            check("model data_err",   32'(data_err),   32'(e_er));
            check("model inst_read",  32'(inst_read),  32'(e_ir));
            check("model inst_done",  32'(inst_done),  32'(e_id));
            check("model stall",      32'(stall),      32'(e_st));
            prev_fin = e_dn | e_er;
        end
    end

    initial begin : stimulus
        rst = 1'b1; memop = '0; memwr = '0; data_ready = '0; inst_ready = 1'b0;
        repeat (3) next_cycle();

        // Reset release and I-fetch timing.
        next_cycle(); rst = 1'b0; settle();
        check("c1 inst_read", 32'(inst_read), 0);
        check("c1 data_read", 32'(data_read), 0);
        next_cycle(); settle();
        check("c2 inst_read", 32'(inst_read), 1);
        repeat (2) next_cycle();
        next_cycle(); inst_ready = 1'b1; settle();
        check("c5 inst_done", 32'(inst_done), 1);
        next_cycle(); inst_ready = 1'b0; settle();
        check("c6 inst_read", 32'(inst_read), 0);
        next_cycle(); settle();
        check("c7 inst_read", 32'(inst_read), 0);
        next_cycle(); settle();
        check("c8 inst_read", 32'(inst_read), 1);

        // Read on channel 0, then a back-to-back request through the release gap.
        next_cycle(); memop = 2'b01; memwr = 2'b00; settle();
        check("rd c0 data_read", 32'(data_read), 1);
        check("rd c0 stall", 32'(stall), 1);
        next_cycle(); settle();
        check("rd c1 inst_read", 32'(inst_read), 0);
        next_cycle();
        next_cycle(); data_ready = 2'b01; settle();
        check("rd c3 data_done", 32'(data_done), 1);
        check("rd c3 stall", 32'(stall), 0);
        next_cycle(); data_ready = 2'b00; settle();
        check("rel c4 data_read", 32'(data_read), 0);
        check("rel c4 stall", 32'(stall), 1);
        next_cycle();
        next_cycle(); settle();
        check("rel c6 data_read", 32'(data_read), 0);
        next_cycle(); settle();
        check("b2b c7 data_read", 32'(data_read), 1);
        next_cycle();
        next_cycle(); data_ready = 2'b01; settle();
        check("b2b c9 data_done", 32'(data_done), 1);
        next_cycle(); data_ready = 2'b00; memop = 2'b00;
        repeat (4) next_cycle();

        // Write on channel 1 interrupts an I-fetch; memwr toggles are ignored.
        next_cycle(); memop = 2'b10; memwr = 2'b10; settle();
        check("wr w0 data_write", 32'(data_write), 2);
        check("wr w0 inst_read", 32'(inst_read), 1);
        next_cycle(); memwr = 2'b00; settle();
        check("wr w1 inst_read", 32'(inst_read), 0);
        check("wr w1 data_write", 32'(data_write), 2);
        check("wr w1 data_read", 32'(data_read), 0);
        next_cycle(); memwr = 2'b10;
        next_cycle(); data_ready = 2'b10; settle();
        check("wr w3 data_done", 32'(data_done), 2);
        next_cycle(); data_ready = 2'b00; memop = 2'b00; settle();
        check("wr w4 inst_read", 32'(inst_read), 1);
        repeat (4) next_cycle();

        // Simultaneous completion, then reset in the middle of a request.
        next_cycle(); memop = 2'b11; memwr = 2'b00;
        next_cycle();
        next_cycle(); data_ready = 2'b11; settle();
        check("dual data_done", 32'(data_done), 3);
        next_cycle(); data_ready = 2'b00; memop = 2'b00;
        repeat (4) next_cycle();
        next_cycle(); memop = 2'b11; memwr = 2'b01;
        next_cycle();
        next_cycle(); rst = 1'b1; data_ready = 2'b11; settle();
        check("rst data_done", 32'(data_done), 0);
        next_cycle(); rst = 1'b0; data_ready = 2'b00; memop = 2'b00; settle();
        check("post-rst data_read", 32'(data_read), 0);
        check("post-rst data_write", 32'(data_write), 0);
        check("post-rst inst_read", 32'(inst_read), 0);
        check("post-rst stall", 32'(stall), 0);
        repeat (2) next_cycle();

        // Request that the cache never answers.
        next_cycle(); memop = 2'b01; memwr = 2'b00; settle();
        check("to t0 data_read", 32'(data_read), 1);
`ifdef MEMIF_TIMEOUT_EN
        repeat (7) next_cycle();
        next_cycle(); settle();
        check("to t8 data_err", 32'(data_err), 1);
        check("to t8 data_done", 32'(data_done), 0);
        next_cycle(); memop = 2'b00; settle();
        check("to t9 data_read", 32'(data_read), 0);
`else
        repeat (99) next_cycle();
        settle();
        check("hold t99 data_read", 32'(data_read), 1);
        check("hold t99 data_err", 32'(data_err), 0);
        next_cycle(); data_ready = 2'b01; settle();
        check("hold done", 32'(data_done), 1);
        next_cycle(); data_ready = 2'b00; memop = 2'b00;
`endif
        repeat (4) next_cycle();

        // Randomized traffic; the pipeline holds memop until done or err.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NUM_DCH; i++) begin
                if (memop[i] && prev_fin[i]) memop[i] = ($urandom_range(0, 1) == 0);
                else if (!memop[i]) memop[i] = ($urandom_range(0, 2) == 0);
                memwr[i]      = 1'($urandom_range(0, 1));
                data_ready[i] = ($urandom_range(0, 3) == 0);
            end
            inst_ready = ($urandom_range(0, 3) == 0);
        end

        next_cycle(); rst = 1'b0; memop = '0; data_ready = '0; inst_ready = 1'b0;
        repeat (2) next_cycle();
        settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
